// File: rtl/branch_resolve_scheduler_if.sv
`default_nettype none
//============================================================================
// Module      : branch_resolve_scheduler_if
// Description : Request lanes, shared address-calculator link and result bus
//               for the branch resolve scheduler.
// Revision    : 1.0  initial release
//============================================================================
interface branch_resolve_scheduler_if #(
    parameter int TAG_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_pc;
    logic [31:0]      req0_imm;
    logic [1:0]       req0_ctrl;
    logic             req0_taken;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_pc;
    logic [31:0]      req1_imm;
    logic [1:0]       req1_ctrl;
    logic             req1_taken;
    logic [TAG_W-1:0] req1_tag;

    logic [1:0]       cal_pc_control;
    logic [31:0]      cal_pc_value;
    logic [31:0]      cal_imm;
    logic [31:0]      cal_target;
    logic [31:0]      cal_plus4;

    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic [31:0]      res_target;
    logic [31:0]      res_link;
    logic             res_redirect;
    logic [31:0]      redirect_cnt;

    // Environment side: issue lanes plus the Branch_Address_Cal datapath
    modport master (
        output req0_valid, req0_pc, req0_imm, req0_ctrl, req0_taken, req0_tag,
        input  req0_ready,
        output req1_valid, req1_pc, req1_imm, req1_ctrl, req1_taken, req1_tag,
        input  req1_ready,
        input  cal_pc_control, cal_pc_value, cal_imm,
        output cal_target, cal_plus4,
        input  res_valid, res_tag, res_target, res_link, res_redirect, redirect_cnt
    );

    modport slave (
        input  req0_valid, req0_pc, req0_imm, req0_ctrl, req0_taken, req0_tag,
        output req0_ready,
        input  req1_valid, req1_pc, req1_imm, req1_ctrl, req1_taken, req1_tag,
        output req1_ready,
        output cal_pc_control, cal_pc_value, cal_imm,
        input  cal_target, cal_plus4,
        output res_valid, res_tag, res_target, res_link, res_redirect, redirect_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_scheduler.sv
`default_nettype none
//============================================================================
// Module      : branch_resolve_scheduler
// Description : In-order queue feeding both issue lanes' branch/jump requests
//               into one shared address calculator; registers results and
//               squashes younger work on a taken redirect.
// Revision    : 1.0  initial release
//============================================================================
module branch_resolve_scheduler #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 flush,
    branch_resolve_scheduler_if.slave bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_M1 = c_CNT_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_M2 = c_CNT_W'(DEPTH - 2);

    logic [31:0]      r_pc    [DEPTH];
    logic [31:0]      r_imm   [DEPTH];
    logic [1:0]       r_ctrl  [DEPTH];
    logic             r_taken [DEPTH];
    logic [TAG_W-1:0] r_tag   [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic             r_res_valid;
    logic [TAG_W-1:0] r_res_tag;
    logic [31:0]      r_res_target;
    logic [31:0]      r_res_link;
    logic             r_res_redirect;
    logic [31:0]      r_redirect_cnt;

    logic               w_squash;
    logic               w_block;
    logic               w_empty;
    logic               w_lane1_room;
    logic               w_push0;
    logic               w_push1;
    logic               w_issue;
    logic               w_head_redirect;
    logic [c_PTR_W-1:0] w_wr_idx1;

    assign w_squash = r_res_valid & r_res_redirect;
    assign w_block  = rst | flush | w_squash;
    assign w_empty  = (r_count == '0);

    // Lane1 needs two free slots when lane0 is also asking, so it can never overtake lane0
    assign w_lane1_room   = bus.req0_valid ? (r_count <= c_DEPTH_M2) : (r_count <= c_DEPTH_M1);
    assign bus.req0_ready = ~w_block & (r_count <= c_DEPTH_M1);
    assign bus.req1_ready = ~w_block & w_lane1_room;

    assign w_push0   = bus.req0_valid & bus.req0_ready;
    assign w_push1   = bus.req1_valid & bus.req1_ready;
    assign w_issue   = ~w_empty & ~w_block;
    assign w_wr_idx1 = w_push0 ? (r_wr_ptr + c_PTR_W'(1)) : r_wr_ptr;

    assign w_head_redirect = (r_ctrl[r_rd_ptr] == 2'b10) |
                             ((r_ctrl[r_rd_ptr] == 2'b11) & r_taken[r_rd_ptr]);

    always_comb begin
        bus.cal_pc_control = 2'b00;
        bus.cal_pc_value   = 32'd0;
        bus.cal_imm        = 32'd0;
        if (!w_empty) begin
            bus.cal_pc_control = r_ctrl[r_rd_ptr];
            bus.cal_pc_value   = r_pc[r_rd_ptr];
            bus.cal_imm        = r_imm[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push0) begin
            r_pc[r_wr_ptr]    <= bus.req0_pc;
            r_imm[r_wr_ptr]   <= bus.req0_imm;
            r_ctrl[r_wr_ptr]  <= bus.req0_ctrl;
            r_taken[r_wr_ptr] <= bus.req0_taken;
            r_tag[r_wr_ptr]   <= bus.req0_tag;
        end
        if (w_push1) begin
            r_pc[w_wr_idx1]    <= bus.req1_pc;
            r_imm[w_wr_idx1]   <= bus.req1_imm;
            r_ctrl[w_wr_idx1]  <= bus.req1_ctrl;
            r_taken[w_wr_idx1] <= bus.req1_taken;
            r_tag[w_wr_idx1]   <= bus.req1_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_res_valid    <= 1'b0;
            r_res_tag      <= '0;
            r_res_target   <= 32'd0;
            r_res_link     <= 32'd0;
            r_res_redirect <= 1'b0;
            r_redirect_cnt <= 32'd0;
        end else if (flush) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_res_valid    <= 1'b0;
            r_res_tag      <= '0;
            r_res_target   <= 32'd0;
            r_res_link     <= 32'd0;
            r_res_redirect <= 1'b0;
        end else if (w_squash) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_res_valid    <= 1'b0;
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
        end else begin
            r_wr_ptr    <= r_wr_ptr + c_PTR_W'(w_push0) + c_PTR_W'(w_push1);
            r_rd_ptr    <= r_rd_ptr + c_PTR_W'(w_issue);
            r_count     <= r_count + c_CNT_W'(w_push0) + c_CNT_W'(w_push1) - c_CNT_W'(w_issue);
            r_res_valid <= w_issue;
            if (w_issue) begin
                r_res_tag      <= r_tag[r_rd_ptr];
                r_res_target   <= bus.cal_target;
                r_res_link     <= bus.cal_plus4;
                r_res_redirect <= w_head_redirect;
            end
        end
    end

    // A flush kills the result visible in the same cycle
    assign bus.res_valid    = r_res_valid & ~flush;
    assign bus.res_tag      = r_res_tag;
    assign bus.res_target   = r_res_target;
    assign bus.res_link     = r_res_link;
    assign bus.res_redirect = r_res_redirect;
    assign bus.redirect_cnt = r_redirect_cnt;
endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_scheduler.sv
`default_nettype none
//============================================================================
// Module      : tb_branch_resolve_scheduler
// Description : Randomized and directed bench against a queue-based model.
// Revision    : 1.0  initial release
//============================================================================
module tb_branch_resolve_scheduler;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    branch_resolve_scheduler_if #(.TAG_W(TAG_W)) bif ();

    branch_resolve_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bif)
    );

    // Behavioural stand-in for Branch_Address_Cal
    assign bif.cal_target = bif.cal_pc_value + bif.cal_imm;
    assign bif.cal_plus4  = bif.cal_pc_value + 32'd4;

    typedef struct {
        logic [31:0]      pc;
        logic [31:0]      imm;
        logic [1:0]       ctrl;
        logic             taken;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t             q[$];
    logic             m_rv;
    logic [TAG_W-1:0] m_tag;
    logic [31:0]      m_tgt;
    logic [31:0]      m_link;
    logic             m_rd;
    logic [31:0]      m_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_lane(input int lane, input logic v, input logic [1:0] c, input logic t,
                            input logic [31:0] pc, input logic [31:0] imm, input logic [TAG_W-1:0] tag);
        if (lane == 0) begin
            bif.req0_valid = v; bif.req0_ctrl = c; bif.req0_taken = t;
            bif.req0_pc = pc; bif.req0_imm = imm; bif.req0_tag = tag;
        end else begin
            bif.req1_valid = v; bif.req1_ctrl = c; bif.req1_taken = t;
            bif.req1_pc = pc; bif.req1_imm = imm; bif.req1_tag = tag;
        end
    endtask

    task automatic idle();
        set_lane(0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, '0);
        set_lane(1, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, '0);
    endtask

    task automatic rand_lane(input int lane, input int pct_valid);
        set_lane(lane, ($urandom_range(99) < pct_valid), 2'($urandom_range(3)), 1'($urandom_range(1)),
                 $urandom, 32'($signed($urandom_range(4095)) - 2048), TAG_W'($urandom));
    endtask

    task automatic model_clear_res();
        m_rv = 1'b0; m_tag = '0; m_tgt = 32'd0; m_link = 32'd0; m_rd = 1'b0;
    endtask

    // One clock cycle: compare outputs mid-cycle, then advance the model across the edge
    task automatic cycle();
        bit   sq, r0, r1;
        ent_t e0, e1, h;
        sq = m_rv && m_rd;
        r0 = !rst && !flush && !sq && (q.size() < DEPTH);
        r1 = !rst && !flush && !sq && (q.size() + (bif.req0_valid ? 1 : 0) + 1 <= DEPTH);
        e0 = '{bif.req0_pc, bif.req0_imm, bif.req0_ctrl, bif.req0_taken, bif.req0_tag};
        e1 = '{bif.req1_pc, bif.req1_imm, bif.req1_ctrl, bif.req1_taken, bif.req1_tag};
        @(negedge clk);
        check_eq("req0_ready",   64'(bif.req0_ready),   64'(r0));
        check_eq("req1_ready",   64'(bif.req1_ready),   64'(r1));
        check_eq("res_valid",    64'(bif.res_valid),    64'(m_rv && !flush));
        check_eq("res_tag",      64'(bif.res_tag),      64'(m_tag));
        check_eq("res_target",   64'(bif.res_target),   64'(m_tgt));
        check_eq("res_link",     64'(bif.res_link),     64'(m_link));
        check_eq("res_redirect", 64'(bif.res_redirect), 64'(m_rd));
        check_eq("redirect_cnt", 64'(bif.redirect_cnt), 64'(m_cnt));
        check_eq("cal_pc_value", 64'(bif.cal_pc_value), (q.size() != 0) ? 64'(q[0].pc) : 64'd0);
        check_eq("cal_pc_control", 64'(bif.cal_pc_control), (q.size() != 0) ? 64'(q[0].ctrl) : 64'd0);
        if (rst) begin
            q.delete(); model_clear_res(); m_cnt = 32'd0;
        end else if (flush) begin
            q.delete(); model_clear_res();
        end else if (sq) begin
            q.delete(); m_rv = 1'b0; m_cnt = m_cnt + 32'd1;
        end else begin
            if (q.size() != 0) begin
                h      = q.pop_front();
                m_rv   = 1'b1;
                m_tag  = h.tag;
                m_tgt  = h.pc + h.imm;
                m_link = h.pc + 32'd4;
                m_rd   = (h.ctrl == 2'b10) || (h.ctrl == 2'b11 && h.taken);
            end else begin
                m_rv = 1'b0;
            end
            if (bif.req0_valid && r0) q.push_back(e0);
            if (bif.req1_valid && r1) q.push_back(e1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        idle();
        model_clear_res(); m_cnt = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;

        // Single taken branch: target 0x120, link 0x104, one redirect
        set_lane(0, 1'b1, 2'b11, 1'b1, 32'h100, 32'h20, 4'd1);
        cycle(); idle();
        repeat (4) cycle();

        // Both lanes, not-taken branches, tags 3 then 4
        set_lane(0, 1'b1, 2'b11, 1'b0, 32'h200, 32'h40, 4'd3);
        set_lane(1, 1'b1, 2'b11, 1'b0, 32'h204, 32'hFFFF_FFF0, 4'd4);
        cycle(); idle();
        repeat (4) cycle();

        // Back-to-back dual-lane traffic pushes the queue to its limit
        for (int i = 0; i < 6; i++) begin
            set_lane(0, 1'b1, 2'b01, 1'b0, 32'h1000 + 32'(i * 16), 32'h8, TAG_W'(2 * i));
            set_lane(1, 1'b1, 2'b01, 1'b0, 32'h1008 + 32'(i * 16), 32'h8, TAG_W'(2 * i + 1));
            cycle();
        end
        idle();
        repeat (6) cycle();

        // Jump at head with younger entries behind it
        set_lane(0, 1'b1, 2'b10, 1'b0, 32'h3000, 32'h400, 4'd5);
        set_lane(1, 1'b1, 2'b01, 1'b0, 32'h3004, 32'h4, 4'd6);
        cycle();
        set_lane(0, 1'b1, 2'b11, 1'b1, 32'h3008, 32'h10, 4'd7);
        set_lane(1, 1'b1, 2'b01, 1'b0, 32'h300C, 32'h4, 4'd8);
        cycle(); idle();
        repeat (5) cycle();

        // Flush with two entries queued and a result on the bus
        set_lane(0, 1'b1, 2'b01, 1'b0, 32'h4000, 32'h4, 4'd9);
        set_lane(1, 1'b1, 2'b01, 1'b0, 32'h4004, 32'h4, 4'd10);
        cycle();
        set_lane(0, 1'b1, 2'b01, 1'b0, 32'h4008, 32'h4, 4'd11);
        set_lane(1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 4'd0);
        cycle(); idle();
        flush = 1'b1; cycle(); flush = 1'b0;
        repeat (4) cycle();

        // Reset mid-stream
        set_lane(0, 1'b1, 2'b11, 1'b1, 32'h5000, 32'h80, 4'd12);
        set_lane(1, 1'b1, 2'b01, 1'b0, 32'h5004, 32'h4, 4'd13);
        cycle(); idle(); cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        repeat (3) cycle();

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            rand_lane(0, 65);
            rand_lane(1, 55);
            flush = ($urandom_range(39) == 0);
            rst   = ($urandom_range(199) == 0);
            cycle();
        end
        rst = 1'b0; flush = 1'b0; idle();
        repeat (6) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
